cache_fill_arbiter: RTL

Shared main-memory controller for the pipelined 16-bit CPU. It arbitrates the single multi-cycle, pipelined main memory between the I-cache miss handler, the D-cache miss handler and D-side write-through stores. It sequences 8-word block fills by issuing pipelined reads and steering returned words into the requesting cache's data array. It sits between both cache controllers and the memory model, and stalls the pipeline indirectly through the per-requester done/ack handshakes.

---
 rtl/cache_fill_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cache_fill_arbiter.sv
// Main-memory arbiter: store > D fill > I fill; 8-word pipelined fills, done pulses with the last word.
// Grant one cycle after sampling, IDLE turnaround between grants; optional `CACHE_ARB_RR_EN` round-robins the two fills.
module cache_fill_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LAT     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_miss,
  input  logic [ADDR_W-1:0]              i_miss_addr,
  input  logic                           d_miss,
  input  logic [ADDR_W-1:0]              d_miss_addr,
  input  logic                           d_wr_req,
  input  logic [ADDR_W-1:0]              d_wr_addr,
  input  logic [DATA_W-1:0]              d_wr_data,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_valid,
  output logic [DATA_W-1:0]              fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           i_fill_we,
  output logic                           d_fill_we,
  output logic                           i_fill_done,
  output logic                           d_fill_done,
  output logic                           d_wr_ack,
  output logic                           busy
);

  localparam int WORD_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W  = WORD_W + 1;
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << OFF_W) - 1);
  localparam logic [WORD_W:0]   NWORDS    = (WORD_W+1)'(BLOCK_WORDS);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_WORDS - 1);

  if (BLOCK_WORDS < 2 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0 || MEM_LAT < 1) begin : gParamCheck
    $error("cache_fill_arbiter: BLOCK_WORDS must be a power of 2 >= 2 and MEM_LAT >= 1");
  end

  typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE} state_t;

  state_t              state, stateNext;
  logic [ADDR_W-1:0]   baseAddr;
  logic [WORD_W:0]     issueCnt;
  logic [WORD_W-1:0]   retCnt;
  logic                inFill, issuing, lastRet;
  logic                grantD, grantI;

  assign inFill  = (state == FILL_I) || (state == FILL_D);
  assign issuing = inFill && (issueCnt != NWORDS);
  assign lastRet = inFill && mem_valid && (retCnt == LAST_WORD);

`ifdef CACHE_ARB_RR_EN
  // History bit: 1 when the most recent fill went to D; reset means "I last" so D wins first.
  logic lastD;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lastD <= 1'b0;
    end else if (state == IDLE && !d_wr_req) begin
      if (grantD)      lastD <= 1'b1;
      else if (grantI) lastD <= 1'b0;
    end
  end
  assign grantD = d_miss && (!i_miss || !lastD);
`else
  assign grantD = d_miss;
`endif
  assign grantI = i_miss && !grantD;

  always_comb begin
    stateNext   = state;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_data   = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (d_wr_req)    stateNext = WRITE;
        else if (grantD) stateNext = FILL_D;
        else if (grantI) stateNext = FILL_I;
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
        stateNext = IDLE;
      end
      FILL_I, FILL_D: begin
        mem_en = issuing;
        if (issuing) mem_addr = baseAddr | ADDR_W'({issueCnt[WORD_W-1:0], 1'b0});
        fill_data   = mem_rdata;
        fill_word   = retCnt;
        i_fill_we   = (state == FILL_I) && mem_valid;
        d_fill_we   = (state == FILL_D) && mem_valid;
        i_fill_done = (state == FILL_I) && lastRet;
        d_fill_done = (state == FILL_D) && lastRet;
        if (lastRet) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baseAddr <= '0;
      issueCnt <= '0;
      retCnt   <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE) begin
        issueCnt <= '0;
        retCnt   <= '0;
        if (!d_wr_req) begin
          if (grantD)      baseAddr <= d_miss_addr & BASE_MASK;
          else if (grantI) baseAddr <= i_miss_addr & BASE_MASK;
        end
      end else if (inFill) begin
        if (issuing)   issueCnt <= issueCnt + 1'b1;
        if (mem_valid) retCnt   <= retCnt + 1'b1;
      end
    end
  end

endmodule
